// File: rtl/memory_ctrl_if.sv
// Bundle of the core request/response channel and the memory port of memory_ctrl.
// The slave modport is the controller's view; master is the core/memory side.
interface memory_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_typ;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_typ, req_addr, req_wdata, rsp_ready, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_typ, req_addr, req_wdata, rsp_ready, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata
    );
endinterface

// File: rtl/memory_ctrl.sv
// Single-outstanding load/store controller: accepts one core request, checks type
// and alignment, drives a word-addressed memory port with byte lanes, waits for
// mem_ack (bounded by TIMEOUT cycles) and returns an extended load result.
module memory_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    memory_ctrl_if.slave bus
);
    // Counter only needs to reach TIMEOUT-1: the timeout fires on the edge that ends the last allowed cycle.
    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       typ_q, typ_d;
    logic [1:0]       off_q, off_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_wmask_q, mem_wmask_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;

    logic             req_legal;
    logic             req_aligned;
    logic [3:0]       req_mask;
    logic [31:0]      req_lanes;
    logic [31:0]      rd_shift;
    logic [31:0]      load_data;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Decode the incoming request: legality, alignment, byte-lane mask and replicated store data.
    always_comb begin
        req_legal   = (bus.req_typ != 3'd3) && (bus.req_typ[2:1] != 2'b11);
        req_aligned = 1'b1;
        req_mask    = 4'b1111;
        req_lanes   = bus.req_wdata;
        case (bus.req_typ[1:0])
            2'd0: begin
                req_mask  = 4'b0001 << bus.req_addr[1:0];
                req_lanes = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                req_aligned = ~bus.req_addr[0];
                req_mask    = 4'b0011 << bus.req_addr[1:0];
                req_lanes   = {2{bus.req_wdata[15:0]}};
            end
            2'd2: req_aligned = (bus.req_addr[1:0] == 2'b00);
            default: ;
        endcase
    end

    // Extract and extend the addressed byte/half from the returned memory word.
    always_comb begin
        rd_shift = bus.mem_rdata >> {off_q, 3'b000};
        case (typ_q)
            3'd0:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_data = {24'h0, rd_shift[7:0]};
            3'd5:    load_data = {16'h0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        typ_d       = typ_q;
        off_d       = off_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_wmask_d = mem_wmask_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    typ_d = bus.req_typ;
                    off_d = bus.req_addr[1:0];
                    cnt_d = '0;
                    if (req_legal && req_aligned) begin
                        state_d     = ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_wmask_d = bus.req_we ? req_mask : 4'b0000;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = bus.req_we ? req_lanes : '0;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                // Ack is tested before the timeout so an ack in the final allowed cycle still succeeds.
                if (bus.mem_ack || cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~bus.mem_ack;
                    rsp_rdata_d = (bus.mem_ack && !mem_we_q) ? load_data : '0;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wmask_d = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            typ_q       <= '0;
            off_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            typ_q       <= typ_d;
            off_q       <= off_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_wmask_q <= mem_wmask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
endmodule

// File: tb/tb_memory_ctrl.sv
// Bench for memory_ctrl: each transaction is described by a cycle timeline
// (acceptance cycle, memory-access window, response window) computed from the
// access rules; one negedge process compares every output against it.
module tb_memory_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    memory_ctrl_if bus();

    memory_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected timeline of the current transaction (cycle indices counted in posedges).
    int          t_a   = 0;
    int          t_m   = 0;
    int          t_r   = 0;
    int          t_end = 0;
    logic        e_we    = 1'b0;
    logic [3:0]  e_mask  = '0;
    logic [31:0] e_maddr = '0;
    logic [31:0] e_wdata = '0;
    logic [31:0] e_rdata = '0;
    logic        e_err   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference behaviour of one access, from the byte-lane and extension rules.
    function automatic void model(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rword,
                                  output logic ok, output logic [31:0] waddr, output logic [3:0] mask,
                                  output logic [31:0] wd, output logic [31:0] rdata);
        int unsigned t, size, k, val;
        t     = int'(typ);
        k     = addr % 4;
        ok    = (t == 0 || t == 1 || t == 2 || t == 4 || t == 5);
        size  = 32'd1 << (t % 4);
        if (ok && (addr % size) != 0) ok = 1'b0;
        waddr = addr - k;
        mask  = '0;
        wd    = '0;
        rdata = '0;
        if (ok && we) begin
            mask = 4'(((32'd1 << size) - 1) << k);
            for (int i = 0; i < 4; i++)
                wd = wd | (((wdata >> (8 * (i % size))) & 32'hFF) << (8 * i));
        end
        if (ok && !we) begin
            val = rword >> (8 * k);
            if (size < 4) begin
                val = val % (32'd1 << (8 * size));
                if (t < 4 && val >= (32'd1 << (8 * size - 1))) val = val - (32'd1 << (8 * size));
            end
            rdata = val;
        end
    endfunction

    // Per-cycle comparison of all outputs against the expected timeline.
    always @(negedge clk) begin
        bit idle, in_acc, in_rsp;
        if (rst_n) begin
            idle   = (cyc < t_a) || (cyc >= t_end);
            in_acc = !idle && (cyc < t_a + t_m);
            in_rsp = !idle && (cyc >= t_r);
            chk("req_ready", 32'(bus.req_ready), 32'(idle));
            chk("mem_en", 32'(bus.mem_en), 32'(in_acc));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(in_rsp));
            if (in_acc && bus.mem_en) begin
                chk("mem_addr", bus.mem_addr, e_maddr);
                chk("mem_we", 32'(bus.mem_we), 32'(e_we));
                chk("mem_wmask", 32'(bus.mem_wmask), 32'(e_mask));
                if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
            end
            if (in_rsp && bus.rsp_valid) begin
                chk("rsp_rdata", bus.rsp_rdata, e_rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    endtask

    task automatic idle_junk();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_typ   = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        t_a = 0; t_m = 0; t_r = 0; t_end = 0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            idle_junk();
        end
    endtask

    // One transaction: d = ack in the (d+1)-th access cycle (d >= TO means never),
    // r = cycles rsp_ready stays low, abort >= 0 resets that many cycles after acceptance.
    task automatic run_txn(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword,
                           input int d, input int r, input int gap, input int abort);
        logic        ok;
        logic [31:0] wa, wd, rd;
        logic [3:0]  mk;
        model(we, typ, addr, wdata, rword, ok, wa, mk, wd, rd);
        repeat (gap) begin
            @(negedge clk);
            idle_junk();
        end
        @(negedge clk);
        t_a     = cyc + 1;
        t_m     = !ok ? 0 : ((d < TO) ? d + 1 : TO);
        t_r     = t_a + t_m;
        t_end   = t_r + r + 1;
        e_we    = we;
        e_mask  = mk;
        e_maddr = wa;
        e_wdata = wd;
        e_err   = !ok || (d >= TO);
        e_rdata = e_err ? 32'd0 : rd;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_typ   = typ;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        bus.rsp_ready = 1'($urandom_range(0, 1));
        for (int c = t_a; c < t_end; c++) begin
            @(negedge clk);
            if (abort >= 0 && c == t_a + abort) begin
                do_reset();
                return;
            end
            bus.req_valid = (c == t_end - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.req_we    = 1'($urandom);
            bus.req_typ   = 3'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            if (c < t_r) begin
                bus.mem_ack   = (d < TO) && (c == t_a + d);
                bus.mem_rdata = bus.mem_ack ? rword : $urandom;
            end else begin
                bus.mem_ack   = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
            bus.rsp_ready = (c >= t_r) ? (c == t_end - 1) : 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        ok;
        logic [31:0] wa, wd, rd;
        logic [3:0]  mk;

        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_typ   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Hand-computed values pinning the model.
        model(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, ok, wa, mk, wd, rd);
        chk("pin_bs_ok", 32'(ok), 32'd1);
        chk("pin_bs_addr", wa, 32'h100);
        chk("pin_bs_rdata", rd, 32'hFFFF_FF80);
        model(1'b0, 3'd5, 32'h102, 32'h0, 32'hBEEF_0000, ok, wa, mk, wd, rd);
        chk("pin_hu_rdata", rd, 32'h0000_BEEF);
        model(1'b0, 3'd1, 32'h102, 32'h0, 32'hBEEF_0000, ok, wa, mk, wd, rd);
        chk("pin_hs_rdata", rd, 32'hFFFF_BEEF);
        model(1'b1, 3'd1, 32'h22, 32'h1234_ABCD, 32'h0, ok, wa, mk, wd, rd);
        chk("pin_sh_mask", 32'(mk), 32'hC);
        chk("pin_sh_wdata", wd, 32'hABCD_ABCD);
        chk("pin_sh_addr", wa, 32'h20);
        chk("pin_sh_rdata", rd, 32'h0);
        model(1'b0, 3'd2, 32'h6, 32'h0, 32'h0, ok, wa, mk, wd, rd);
        chk("pin_ws_misaligned", 32'(ok), 32'd0);
        model(1'b0, 3'd3, 32'h40, 32'h0, 32'h0, ok, wa, mk, wd, rd);
        chk("pin_typ3_illegal", 32'(ok), 32'd0);

        // Directed transactions.
        run_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1, 0, 1, -1);
        run_txn(1'b0, 3'd5, 32'h102, 32'h0, 32'hBEEF_0000, 0, 1, 0, -1);
        run_txn(1'b0, 3'd1, 32'h102, 32'h0, 32'hBEEF_0000, 0, 0, 0, -1);
        run_txn(1'b1, 3'd1, 32'h22, 32'h1234_ABCD, $urandom, 2, 0, 1, -1);
        run_txn(1'b0, 3'd2, 32'h6, 32'h0, $urandom, 0, 1, 1, -1);
        run_txn(1'b0, 3'd3, 32'h40, 32'h0, $urandom, 0, 0, 0, -1);
        run_txn(1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFE_F00D, 100, 0, 1, -1);
        @(negedge clk);
        idle_junk();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        run_txn(1'b0, 3'd2, 32'h44, 32'h0, 32'h1357_9BDF, TO - 1, 0, 1, -1);
        run_txn(1'b0, 3'd4, 32'h101, 32'h0, 32'h0000_A500, 0, 5, 0, -1);
        run_txn(1'b1, 3'd4, 32'h203, 32'h0000_00E7, $urandom, 1, 0, 0, -1);
        run_txn(1'b0, 3'd2, 32'h80, 32'h0, $urandom, 100, 0, 0, 2);
        run_txn(1'b0, 3'd3, 32'h84, 32'h0, $urandom, 0, 5, 0, 2);

        // Randomized transactions.
        for (int n = 0; n < 300; n++) begin
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 2), -1);
        end
        repeat (3) begin
            @(negedge clk);
            idle_junk();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
